// File: rtl/sram_access_arbiter.sv
// Purpose: shares one async 8-bit SRAM between loader (wr), CPU (rd/wr) and PPU (rd) via fixed-length cycles.
// Latency: req edge to ack-high is ACCESS_CYCLES+1 edges uncontended; one access per ACCESS_CYCLES+2 cycles.
// Backpressure: one buffered request per requester; req while busy is dropped (sticky overrun for the loader).
module sram_access_arbiter #(
    parameter int ADDR_W        = 19,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ldr_req,
    input  logic [21:0]       ldr_addr,
    input  logic [7:0]        ldr_wdata,
    output logic              ldr_busy,
    output logic              ldr_ack,
    output logic              ldr_overrun,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [21:0]       cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_busy,
    output logic              cpu_ack,
    input  logic              ppu_req,
    input  logic [21:0]       ppu_addr,
    output logic [7:0]        ppu_rdata,
    output logic              ppu_busy,
    output logic              ppu_ack,
    output logic [ADDR_W-1:0] ram_a,
    output logic [7:0]        ram_dout,
    output logic              ram_oe,
    output logic              ram_we_n,
    input  logic [7:0]        ram_din
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    typedef enum logic [1:0] {SRC_LDR, SRC_CPU, SRC_PPU} src_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [7:0]        wdat;
    } slot_t;

    localparam logic [3:0] CNT_INIT = 4'(ACCESS_CYCLES - 1);

    slot_t      ldr_slot, cpu_slot, ppu_slot, sel_slot;
    logic       ldr_pend, cpu_pend, ppu_pend;
    logic       any_pend, grant;
    src_t       sel_src, gnt;
    state_t     state;
    logic       rr;
    logic       is_wr;
    logic [3:0] cnt;

    // Upper requester address bits are deliberately discarded.
    if (ADDR_W < 22) begin : g_trunc
        logic unused_upper;
        assign unused_upper = ^{ldr_addr[21:ADDR_W], cpu_addr[21:ADDR_W], ppu_addr[21:ADDR_W]};
    end

    assign ldr_busy = ldr_pend | (state == ACCESS && gnt == SRC_LDR);
    assign cpu_busy = cpu_pend | (state == ACCESS && gnt == SRC_CPU);
    assign ppu_busy = ppu_pend | (state == ACCESS && gnt == SRC_PPU);

    assign any_pend = ldr_pend | cpu_pend | ppu_pend;
    assign grant    = (state == IDLE) && any_pend;

    always_comb begin
        sel_src  = SRC_LDR;
        sel_slot = ldr_slot;
        if (ldr_pend) begin
            sel_src  = SRC_LDR;
            sel_slot = ldr_slot;
        end else if (cpu_pend && (!ppu_pend || !rr)) begin
            sel_src  = SRC_CPU;
            sel_slot = cpu_slot;
        end else if (ppu_pend) begin
            sel_src  = SRC_PPU;
            sel_slot = ppu_slot;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ldr_pend    <= 1'b0;
            cpu_pend    <= 1'b0;
            ppu_pend    <= 1'b0;
            ldr_overrun <= 1'b0;
            ldr_slot    <= '0;
            cpu_slot    <= '0;
            ppu_slot    <= '0;
        end else begin
            if (grant) begin
                case (sel_src)
                    SRC_LDR: ldr_pend <= 1'b0;
                    SRC_CPU: cpu_pend <= 1'b0;
                    SRC_PPU: ppu_pend <= 1'b0;
                    default: ;
                endcase
            end
            if (ldr_req) begin
                if (ldr_busy) begin
                    ldr_overrun <= 1'b1;
                end else begin
                    ldr_pend      <= 1'b1;
                    ldr_slot.addr <= ldr_addr[ADDR_W-1:0];
                    ldr_slot.we   <= 1'b1;
                    ldr_slot.wdat <= ldr_wdata;
                end
            end
            if (cpu_req && !cpu_busy) begin
                cpu_pend      <= 1'b1;
                cpu_slot.addr <= cpu_addr[ADDR_W-1:0];
                cpu_slot.we   <= cpu_we;
                cpu_slot.wdat <= cpu_wdata;
            end
            if (ppu_req && !ppu_busy) begin
                ppu_pend      <= 1'b1;
                ppu_slot.addr <= ppu_addr[ADDR_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            gnt       <= SRC_LDR;
            rr        <= 1'b0;
            is_wr     <= 1'b0;
            cnt       <= '0;
            ram_a     <= '0;
            ram_dout  <= '0;
            ram_oe    <= 1'b0;
            ram_we_n  <= 1'b1;
            ldr_ack   <= 1'b0;
            cpu_ack   <= 1'b0;
            ppu_ack   <= 1'b0;
            cpu_rdata <= '0;
            ppu_rdata <= '0;
        end else begin
            ldr_ack <= 1'b0;
            cpu_ack <= 1'b0;
            ppu_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_pend) begin
                        state <= ACCESS;
                        gnt   <= sel_src;
                        cnt   <= CNT_INIT;
                        ram_a <= sel_slot.addr;
                        is_wr <= sel_slot.we;
                        if (sel_src == SRC_CPU)
                            rr <= 1'b1;
                        else if (sel_src == SRC_PPU)
                            rr <= 1'b0;
                        if (sel_slot.we) begin
                            ram_dout <= sel_slot.wdat;
                            ram_oe   <= 1'b1;
                            ram_we_n <= 1'b0;
                        end else begin
                            ram_oe <= 1'b0;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        // Address, data and oe stay put through this edge so read data is stable.
                        state <= DONE;
                        case (gnt)
                            SRC_LDR: ldr_ack <= 1'b1;
                            SRC_CPU: begin
                                cpu_ack <= 1'b1;
                                if (!is_wr)
                                    cpu_rdata <= ram_din;
                            end
                            SRC_PPU: begin
                                ppu_ack   <= 1'b1;
                                ppu_rdata <= ram_din;
                            end
                            default: ;
                        endcase
                    end else begin
                        cnt <= cnt - 4'd1;
                        if (cnt == 4'd1)
                            ram_we_n <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    ram_oe <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Directed bench: two arbiter builds (2- and 4-cycle access) each backed by a small SRAM model.
module tb_sram_access_arbiter;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic        a_ldr_req = 1'b0, a_cpu_req = 1'b0, a_cpu_we = 1'b0, a_ppu_req = 1'b0;
    logic [21:0] a_ldr_addr = '0, a_cpu_addr = '0, a_ppu_addr = '0;
    logic [7:0]  a_ldr_wdata = '0, a_cpu_wdata = '0;
    logic        a_ldr_busy, a_ldr_ack, a_ldr_overrun, a_cpu_busy, a_cpu_ack, a_ppu_busy, a_ppu_ack;
    logic [7:0]  a_cpu_rdata, a_ppu_rdata, a_ram_dout, a_ram_din;
    logic [18:0] a_ram_a;
    logic        a_ram_oe, a_ram_we_n;

    logic        b_ldr_req = 1'b0, b_cpu_req = 1'b0, b_cpu_we = 1'b0;
    logic [21:0] b_ldr_addr = '0, b_cpu_addr = '0;
    logic [7:0]  b_ldr_wdata = '0;
    logic        b_ldr_busy, b_ldr_ack, b_unused_ovr, b_cpu_busy, b_cpu_ack, b_unused_pbusy, b_unused_pack;
    logic [7:0]  b_cpu_rdata, b_unused_prdata, b_ram_dout, b_ram_din;
    logic [18:0] b_ram_a;
    logic        b_unused_oe, b_ram_we_n;

    sram_access_arbiter #(.ADDR_W(19), .ACCESS_CYCLES(2)) dut_a (
        .clk(clk), .reset_n(reset_n),
        .ldr_req(a_ldr_req), .ldr_addr(a_ldr_addr), .ldr_wdata(a_ldr_wdata),
        .ldr_busy(a_ldr_busy), .ldr_ack(a_ldr_ack), .ldr_overrun(a_ldr_overrun),
        .cpu_req(a_cpu_req), .cpu_we(a_cpu_we), .cpu_addr(a_cpu_addr), .cpu_wdata(a_cpu_wdata),
        .cpu_rdata(a_cpu_rdata), .cpu_busy(a_cpu_busy), .cpu_ack(a_cpu_ack),
        .ppu_req(a_ppu_req), .ppu_addr(a_ppu_addr), .ppu_rdata(a_ppu_rdata),
        .ppu_busy(a_ppu_busy), .ppu_ack(a_ppu_ack),
        .ram_a(a_ram_a), .ram_dout(a_ram_dout), .ram_oe(a_ram_oe), .ram_we_n(a_ram_we_n),
        .ram_din(a_ram_din)
    );

    sram_access_arbiter #(.ADDR_W(19), .ACCESS_CYCLES(4)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .ldr_req(b_ldr_req), .ldr_addr(b_ldr_addr), .ldr_wdata(b_ldr_wdata),
        .ldr_busy(b_ldr_busy), .ldr_ack(b_ldr_ack), .ldr_overrun(b_unused_ovr),
        .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr), .cpu_wdata(8'h00),
        .cpu_rdata(b_cpu_rdata), .cpu_busy(b_cpu_busy), .cpu_ack(b_cpu_ack),
        .ppu_req(1'b0), .ppu_addr(22'h0), .ppu_rdata(b_unused_prdata),
        .ppu_busy(b_unused_pbusy), .ppu_ack(b_unused_pack),
        .ram_a(b_ram_a), .ram_dout(b_ram_dout), .ram_oe(b_unused_oe), .ram_we_n(b_ram_we_n),
        .ram_din(b_ram_din)
    );

    // Async SRAM models: write while we_n is low, read combinationally.
    logic [7:0] mem_a [0:255];
    logic [7:0] mem_b [0:255];
    assign a_ram_din = mem_a[a_ram_a[7:0]];
    assign b_ram_din = mem_b[b_ram_a[7:0]];

    int a_we_low = 0, b_we_low = 0, a_ldr_acks = 0;
    always @(posedge clk) begin
        if (!a_ram_we_n) begin
            mem_a[a_ram_a[7:0]] <= a_ram_dout;
            a_we_low <= a_we_low + 1;
        end
        if (!b_ram_we_n) begin
            mem_b[b_ram_a[7:0]] <= b_ram_dout;
            b_we_low <= b_we_low + 1;
        end
        if (a_ldr_ack)
            a_ldr_acks <= a_ldr_acks + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Edge 0 is the request-capture edge; returns the edge index of each first ack (-1 if none).
    task automatic run_a(input int max, output int e_l, output int e_c, output int e_p);
        e_l = -1; e_c = -1; e_p = -1;
        for (int i = 0; i < max; i++) begin
            @(posedge clk); #1;
            if (i == 0) begin
                a_ldr_req = 1'b0; a_cpu_req = 1'b0; a_ppu_req = 1'b0;
            end
            if (a_ldr_ack && e_l < 0) e_l = i;
            if (a_cpu_ack && e_c < 0) e_c = i;
            if (a_ppu_ack && e_p < 0) e_p = i;
        end
    endtask

    task automatic run_b(input int max, output int e_l, output int e_c);
        e_l = -1; e_c = -1;
        for (int i = 0; i < max; i++) begin
            @(posedge clk); #1;
            if (i == 0) begin
                b_ldr_req = 1'b0; b_cpu_req = 1'b0;
            end
            if (b_ldr_ack && e_l < 0) e_l = i;
            if (b_cpu_ack && e_c < 0) e_c = i;
        end
    endtask

    initial begin
        int el, ec, ep, base, last, alt_err, n_ack, first;
        #1 reset_n = 1'b0;
        #11;
        chk("rst_we_n", a_ram_we_n, 1);
        chk("rst_oe", a_ram_oe, 0);
        chk("rst_addr_dout", {a_ram_a, a_ram_dout}, 0);
        chk("rst_busy_ack", {a_ldr_busy, a_cpu_busy, a_ppu_busy, a_ldr_ack, a_cpu_ack, a_ppu_ack}, 0);
        chk("rst_rdata_ovr", {a_cpu_rdata, a_ppu_rdata, a_ldr_overrun}, 0);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_we_oe", {a_ram_we_n, a_ram_oe}, 2'b10);

        // Loader write 0x10 <- 0xA5, edge by edge
        base = a_we_low;
        a_ldr_req = 1'b1; a_ldr_addr = 22'h00010; a_ldr_wdata = 8'hA5;
        @(posedge clk); #1; a_ldr_req = 1'b0;
        chk("ldr_busy_r0", a_ldr_busy, 1);
        chk("ldr_we_n_r0", a_ram_we_n, 1);
        @(posedge clk); #1;
        chk("ldr_ram_a_e0", a_ram_a, 19'h10);
        chk("ldr_dout_e0", a_ram_dout, 8'hA5);
        chk("ldr_oe_we_e0", {a_ram_oe, a_ram_we_n}, 2'b10);
        @(posedge clk); #1;
        chk("ldr_r2", {a_ram_we_n, a_ldr_busy, a_ldr_ack}, 3'b110);
        @(posedge clk); #1;
        chk("ldr_r3_ack", {a_ldr_ack, a_ldr_busy, a_ram_oe}, 3'b101);
        @(posedge clk); #1;
        chk("ldr_r4", {a_ldr_ack, a_ram_oe}, 0);
        chk("ldr_we_low_cycles", a_we_low - base, 1);

        // CPU read with address bit 21 set: truncated to 0x10
        base = a_we_low;
        a_cpu_req = 1'b1; a_cpu_we = 1'b0; a_cpu_addr = 22'h200010;
        run_a(8, el, ec, ep);
        chk("cpu_rd_ack_edge", ec, 3);
        chk("cpu_rd_data_held", a_cpu_rdata, 8'hA5);
        chk("cpu_rd_no_we", a_we_low - base, 0);

        // Reset in the middle of a write
        a_ldr_req = 1'b1; a_ldr_addr = 22'h00020; a_ldr_wdata = 8'h5A;
        @(posedge clk); #1; a_ldr_req = 1'b0;
        @(posedge clk); #1;
        chk("mid_we_low", a_ram_we_n, 0);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_we_n", a_ram_we_n, 1);
        chk("mid_rst_oe_busy", {a_ram_oe, a_ldr_busy}, 0);
        base = a_ldr_acks;
        @(negedge clk) reset_n = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
        end
        chk("mid_rst_no_ack", a_ldr_acks - base, 0);

        // rr=0 after reset: CPU write and PPU read on the same edge, CPU first
        a_cpu_req = 1'b1; a_cpu_we = 1'b1; a_cpu_addr = 22'h30; a_cpu_wdata = 8'h3C;
        a_ppu_req = 1'b1; a_ppu_addr = 22'h10;
        run_a(10, el, ec, ep);
        chk("pair0_cpu_edge", ec, 3);
        chk("pair0_ppu_edge", ep, 7);
        chk("pair0_ppu_data", a_ppu_rdata, 8'hA5);

        // Lone CPU read sets rr=1
        a_cpu_req = 1'b1; a_cpu_we = 1'b0; a_cpu_addr = 22'h30;
        run_a(8, el, ec, ep);
        chk("lone_cpu_edge", ec, 3);
        chk("lone_cpu_data", a_cpu_rdata, 8'h3C);

        // rr=1: PPU first
        a_cpu_req = 1'b1; a_cpu_we = 1'b0; a_cpu_addr = 22'h10;
        a_ppu_req = 1'b1; a_ppu_addr = 22'h30;
        run_a(10, el, ec, ep);
        chk("pair1_ppu_edge", ep, 3);
        chk("pair1_cpu_edge", ec, 7);
        chk("pair1_data", {a_cpu_rdata, a_ppu_rdata}, 16'hA53C);

        // Sustained traffic from both, re-requesting as soon as busy drops
        last = 0; alt_err = 0; n_ack = 0; first = 0;
        a_cpu_req = 1'b1; a_ppu_req = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (a_cpu_ack) begin
                if (last == 1) alt_err++;
                if (first == 0) first = 1;
                last = 1; n_ack++;
            end
            if (a_ppu_ack) begin
                if (last == 2) alt_err++;
                if (first == 0) first = 2;
                last = 2; n_ack++;
            end
            a_cpu_req = !a_cpu_busy;
            a_ppu_req = !a_ppu_busy;
        end
        chk("sust_first_ppu", first, 2);
        chk("sust_alternate", alt_err, 0);
        chk("sust_enough_acks", n_ack >= 8, 1);
        run_a(14, el, ec, ep);
        chk("sust_drained", {a_ldr_busy, a_cpu_busy, a_ppu_busy}, 0);

        // All three at once, then a loader re-request while busy
        base = a_ldr_acks;
        a_ldr_req = 1'b1; a_ldr_addr = 22'h40; a_ldr_wdata = 8'h77;
        a_cpu_req = 1'b1; a_cpu_we = 1'b0; a_cpu_addr = 22'h10;
        a_ppu_req = 1'b1; a_ppu_addr = 22'h30;
        @(posedge clk); #1;
        a_cpu_req = 1'b0; a_ppu_req = 1'b0;
        a_ldr_addr = 22'h41; a_ldr_wdata = 8'h99;
        run_a(16, el, ec, ep);
        chk("all3_ldr_edge", el, 2);
        chk("all3_ldr_first", (el < ec) && (el < ep) && (ec > 0) && (ep > 0), 1);
        chk("all3_one_ldr_ack", a_ldr_acks - base, 1);
        chk("all3_data", {a_cpu_rdata, a_ppu_rdata}, 16'hA53C);
        chk("overrun_set", a_ldr_overrun, 1);
        repeat (5) begin
            @(posedge clk); #1;
        end
        chk("overrun_sticky", a_ldr_overrun, 1);

        // 4-cycle build: write then read same address
        base = b_we_low;
        b_ldr_req = 1'b1; b_ldr_addr = 22'h55; b_ldr_wdata = 8'hC3;
        run_b(10, el, ec);
        chk("b_ldr_edge", el, 5);
        chk("b_we_low_cycles", b_we_low - base, 3);
        b_cpu_req = 1'b1; b_cpu_we = 1'b0; b_cpu_addr = 22'h55;
        run_b(10, el, ec);
        chk("b_cpu_edge", ec, 5);
        chk("b_cpu_data", b_cpu_rdata, 8'hC3);

        @(negedge clk) reset_n = 1'b0;
        @(negedge clk) reset_n = 1'b1;
        chk("overrun_cleared", a_ldr_overrun, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
